min_sopc: RTL and testbench
===========================

Name: min_sopc

Overview:
- Minimal system-on-programmable-chip: a 5-stage in-order MIPS32-subset pipeline (IF/ID/EX/MEM/WB) plus a word-organised instruction ROM.
- Purpose: exercises the pipeline, especially EX→ID and MEM→ID result forwarding for back-to-back dependent instructions.
- Top level of the simulation; no external buses. Program is preloaded into the ROM array by the bench.

Parameters:
- ROM_DEPTH, 1024, number of 32-bit instruction words in the ROM.
- ROM_AW, 10, ROM word-address width (log2 ROM_DEPTH).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Hierarchy is fixed; benches reach into it:
  - ROM instance `inst_rom0`, with memory array `inst_mem` [0:ROM_DEPTH-1] of 32 bits, loadable by $readmemh of hex words.
  - CPU instance `cpu`, containing register-file instance `register` with array `storage` [0:31] of 32 bits.
- PC register:
  - Reset: pc=0, ce=0.
  - First rising edge with rst=0 sets ce=1; pc stays 0.
  - Each later edge: pc <= pc+4. No branches.
- ROM: combinational read. inst = ce ? inst_mem[pc[ROM_AW+1:2]] : 0.
- Pipeline registers IF/ID, ID/EX, EX/MEM, MEM/WB:
  - Clear to NOP on rst: all fields 0, write-enable 0.
  - Advance every cycle; no stalls.
- Register file:
  - 32×32; $0 reads 0 and ignores writes.
  - Written on the rising edge when WB we=1.
  - Two async read ports, with write-through bypass: same-cycle WB write to the read address returns the write data.
  - storage is not cleared by reset, except $0 = 0.
- ID operand selection priority:
  - 1. EX-stage result if EX we and waddr==raddr≠0.
  - 2. MEM-stage result under the same conditions.
  - 3. Register-file read.
  - Immediate operand when the instruction uses one.
- Supported ISA:
  - ORI, ANDI, XORI: zero-extended imm16.
  - LUI: imm16<<16.
  - SPECIAL funct OR/AND/XOR/NOR.
  - NOP: all zeros.
  - Any other opcode: NOP (we=0).
- Latency: instruction at word k is written to its destination at the (6+k)-th rising edge after the first edge that samples rst=0. Results are visible in storage immediately after that edge.
- rst asserted mid-run: next edge zeroes pc/ce and flushes all stages; in-flight writes are discarded.

Decomposition:
- Shared package holds:
  - opcode/funct constants (ORI=6'h0D, ANDI=6'h0C, XORI=6'h0E, LUI=6'h0F, SPECIAL=6'h00; funct OR=6'h25, AND=6'h24, XOR=6'h26, NOR=6'h27);
  - ALU-op enum;
  - NOP word;
  - register-address width.
- Sub-modules: `cpu` (pc_reg, stage logic, pipeline registers, `register` regfile) and `inst_rom`.
- A separate `regfile` sub-module is natural; its instance must be named `register`.

Test Plan:
- Forwarding chain:
  - ROM = ori $5,$0,0x1100; ori $5,$5,0x0020; ori $5,$5,0x4400; ori $5,$5,0x0044.
  - Clock 2 ns, rst high 0–20 ns.
  - Required: storage[5] = 0x00001100 at 32 ns, 0x00001120 at 34 ns, 0x00005520 at 36 ns, 0x00005564 at 38 ns.
- MEM-distance forwarding:
  - ori $1,$0,0x00F0; nop; or $2,$1,$0.
  - Required: $2=0x000000F0 after its write edge.
- Regfile write-through:
  - ori $3,$0,0x0F0F; nop; nop; xori $4,$3,0x00FF.
  - Required: $4=0x00000FF0.
- $0 protection:
  - ori $0,$0,0x1234; or $6,$0,$0.
  - Required: $0 and $6 both read 0.
- LUI/NOR/unknown opcode:
  - lui $7,0xABCD; nor $8,$7,$0; then word 0xFC000000.
  - Required: $7=0xABCD0000, $8=0x5432FFFF; the unknown opcode writes nothing.
- Mid-run reset:
  - Assert rst for one edge during the first test's chain.
  - Required: pc restarts at 0; the sequence replays and storage[5] ends at 0x00005564.

Source files
------------

// File: rtl/min_sopc_pkg.sv
// Shared definitions for the min_sopc pipeline: ISA encodings, ALU
// operation set, pipeline-register layouts and small datapath helpers.
`timescale 1ns/1ps
package min_sopc_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL function codes
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_OR  = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_NOR = 3'd4
    } alu_op_e;

    // ID/EX register: operation plus already-resolved operands
    typedef struct packed {
        alu_op_e             alu_op;
        logic [DATA_W-1:0]   op1;
        logic [DATA_W-1:0]   op2;
        logic                we;
        logic [REG_AW-1:0]   waddr;
    } id_ex_t;

    // EX/MEM and MEM/WB registers: a pending register-file write
    typedef struct packed {
        logic                we;
        logic [REG_AW-1:0]   waddr;
        logic [DATA_W-1:0]   wdata;
    } wb_t;

    localparam id_ex_t ID_EX_NOP = '{alu_op: ALU_NOP, op1: 32'h0, op2: 32'h0,
                                     we: 1'b0, waddr: 5'd0};
    localparam wb_t    WB_NOP    = '{we: 1'b0, waddr: 5'd0, wdata: 32'h0};

    function automatic logic [DATA_W-1:0] alu_exec(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Operand source: youngest in-flight producer wins, then the regfile.
    // $0 is never forwarded so it always reads as zero.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [REG_AW-1:0] raddr,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_waddr,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_waddr,
        input logic [DATA_W-1:0] mem_data,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] r;
        if (ex_we && (ex_waddr == raddr) && (raddr != 5'd0)) begin
            r = ex_data;
        end else if (mem_we && (mem_waddr == raddr) && (raddr != 5'd0)) begin
            r = mem_data;
        end else begin
            r = rf_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/min_sopc_cpu.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB). No stalls or
// branches; dependent back-to-back instructions are served by EX->ID and
// MEM->ID forwarding plus regfile write-through for WB distance.
`timescale 1ns/1ps
module min_sopc_cpu
    import min_sopc_pkg::*;
#(
    parameter int ROM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       rom_inst_i,
    output logic              rom_ce_o,
    output logic [ROM_AW-1:0] rom_addr_o
);

    // ---------------- IF: program counter ----------------
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;

    // Next PC: first enabled cycle only raises ce, afterwards step one word
    always_comb begin
        pc_d = pc_q;
        ce_d = ce_q;
        if (!ce_q) begin
            ce_d = 1'b1;
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC / fetch-enable registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= 32'h0;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q[ROM_AW+1:2];

    // ---------------- IF/ID ----------------
    logic [31:0] if_id_inst_q;

    // IF/ID instruction register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_inst_q <= NOP_WORD;
        end else begin
            if_id_inst_q <= rom_inst_i;
        end
    end

    // ---------------- ID: decode ----------------
    logic [5:0]        id_opcode_s, id_funct_s;
    logic [REG_AW-1:0] id_rs_s, id_rt_s, id_rd_s;
    logic [15:0]       id_imm16_s;

    assign id_opcode_s = if_id_inst_q[31:26];
    assign id_rs_s     = if_id_inst_q[25:21];
    assign id_rt_s     = if_id_inst_q[20:16];
    assign id_rd_s     = if_id_inst_q[15:11];
    assign id_imm16_s  = if_id_inst_q[15:0];
    assign id_funct_s  = if_id_inst_q[5:0];

    alu_op_e           id_alu_op_s;
    logic              id_we_s;
    logic [REG_AW-1:0] id_waddr_s;
    logic              id_use_rs_s;
    logic              id_use_imm_s;
    logic [DATA_W-1:0] id_imm_s;

    // Instruction decode; anything unrecognised becomes a NOP
    always_comb begin
        id_alu_op_s  = ALU_NOP;
        id_we_s      = 1'b0;
        id_waddr_s   = 5'd0;
        id_use_rs_s  = 1'b1;
        id_use_imm_s = 1'b0;
        id_imm_s     = 32'h0;
        case (id_opcode_s)
            OP_ORI, OP_ANDI, OP_XORI: begin
                id_alu_op_s  = (id_opcode_s == OP_ORI)  ? ALU_OR  :
                               (id_opcode_s == OP_ANDI) ? ALU_AND : ALU_XOR;
                id_we_s      = 1'b1;
                id_waddr_s   = id_rt_s;
                id_use_imm_s = 1'b1;
                id_imm_s     = {16'h0000, id_imm16_s};
            end
            OP_LUI: begin
                // rs is ignored: result is simply the shifted immediate
                id_alu_op_s  = ALU_OR;
                id_we_s      = 1'b1;
                id_waddr_s   = id_rt_s;
                id_use_rs_s  = 1'b0;
                id_use_imm_s = 1'b1;
                id_imm_s     = {id_imm16_s, 16'h0000};
            end
            OP_SPECIAL: begin
                id_waddr_s = id_rd_s;
                case (id_funct_s)
                    FN_OR:  begin id_alu_op_s = ALU_OR;  id_we_s = 1'b1; end
                    FN_AND: begin id_alu_op_s = ALU_AND; id_we_s = 1'b1; end
                    FN_XOR: begin id_alu_op_s = ALU_XOR; id_we_s = 1'b1; end
                    FN_NOR: begin id_alu_op_s = ALU_NOR; id_we_s = 1'b1; end
                    default: begin
                        id_alu_op_s = ALU_NOP;
                        id_we_s     = 1'b0;
                        id_waddr_s  = 5'd0;
                    end
                endcase
            end
            default: begin
                id_alu_op_s = ALU_NOP;
                id_we_s     = 1'b0;
            end
        endcase
    end

    // ---------------- regfile and forwarding ----------------
    id_ex_t            id_ex_q, id_ex_d;
    wb_t               ex_mem_q, ex_mem_d;
    wb_t               mem_wb_q;
    logic [DATA_W-1:0] ex_result_s;
    logic [DATA_W-1:0] rf_rdata1_s, rf_rdata2_s;
    logic [DATA_W-1:0] id_op1_s, id_op2_s;

    min_sopc_regfile register (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (mem_wb_q.we),
        .waddr_i  (mem_wb_q.waddr),
        .wdata_i  (mem_wb_q.wdata),
        .raddr1_i (id_rs_s),
        .rdata1_o (rf_rdata1_s),
        .raddr2_i (id_rt_s),
        .rdata2_o (rf_rdata2_s)
    );

    // Operand 1: rs with forwarding, or zero when the instruction ignores rs
    always_comb begin
        id_op1_s = 32'h0;
        if (id_use_rs_s) begin
            id_op1_s = fwd_pick(id_rs_s, id_ex_q.we, id_ex_q.waddr, ex_result_s,
                                ex_mem_q.we, ex_mem_q.waddr, ex_mem_q.wdata,
                                rf_rdata1_s);
        end else begin
            id_op1_s = 32'h0;
        end
    end

    // Operand 2: immediate, or rt with forwarding
    always_comb begin
        id_op2_s = 32'h0;
        if (id_use_imm_s) begin
            id_op2_s = id_imm_s;
        end else begin
            id_op2_s = fwd_pick(id_rt_s, id_ex_q.we, id_ex_q.waddr, ex_result_s,
                                ex_mem_q.we, ex_mem_q.waddr, ex_mem_q.wdata,
                                rf_rdata2_s);
        end
    end

    // Assemble the ID/EX payload
    always_comb begin
        id_ex_d        = ID_EX_NOP;
        id_ex_d.alu_op = id_alu_op_s;
        id_ex_d.op1    = id_op1_s;
        id_ex_d.op2    = id_op2_s;
        id_ex_d.we     = id_we_s;
        id_ex_d.waddr  = id_waddr_s;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_q <= ID_EX_NOP;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // ---------------- EX ----------------
    assign ex_result_s = alu_exec(id_ex_q.alu_op, id_ex_q.op1, id_ex_q.op2);

    // Assemble the EX/MEM payload
    always_comb begin
        ex_mem_d       = WB_NOP;
        ex_mem_d.we    = id_ex_q.we;
        ex_mem_d.waddr = id_ex_q.waddr;
        ex_mem_d.wdata = ex_result_s;
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_mem_q <= WB_NOP;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // ---------------- MEM (pass-through, no load/store) ----------------
    // MEM/WB pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_wb_q <= WB_NOP;
        end else begin
            mem_wb_q <= ex_mem_q;
        end
    end

endmodule

// File: rtl/min_sopc_inst_rom.sv
// Word-organised instruction ROM with a combinational read port.
// The array is preloaded from outside by the bench.
`timescale 1ns/1ps
module min_sopc_inst_rom
    import min_sopc_pkg::*;
#(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input  logic              ce_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [31:0]       inst_o
);

    logic [31:0] inst_mem [0:ROM_DEPTH-1];

    // Combinational fetch; a disabled ROM feeds NOPs into the pipeline
    always_comb begin
        inst_o = NOP_WORD;
        if (ce_i) begin
            inst_o = inst_mem[addr_i];
        end else begin
            inst_o = NOP_WORD;
        end
    end

endmodule

// File: rtl/min_sopc_regfile.sv
// 32x32 register file: one write port, two asynchronous read ports with
// same-cycle write-through. Contents survive reset except $0.
`timescale 1ns/1ps
module min_sopc_regfile
    import min_sopc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] storage [0:31];

    // Write port; a write that coincides with reset is dropped, $0 pinned to zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            storage[0] <= 32'h0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            storage[waddr_i] <= wdata_i;
        end else begin
            storage[0] <= 32'h0;
        end
    end

    // Read port 1 with write-through bypass
    always_comb begin
        rdata1_o = 32'h0;
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'h0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = storage[raddr1_i];
        end
    end

    // Read port 2 with write-through bypass
    always_comb begin
        rdata2_o = 32'h0;
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'h0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = storage[raddr2_i];
        end
    end

endmodule

// File: rtl/min_sopc.sv
// Minimal SoPC top: pipelined CPU fetching from a preloaded instruction ROM.
`timescale 1ns/1ps
module min_sopc
    import min_sopc_pkg::*;
#(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input logic clk,
    input logic rst
);

    logic              rom_ce_s;
    logic [ROM_AW-1:0] rom_addr_s;
    logic [DATA_W-1:0] rom_inst_s;

    min_sopc_cpu #(
        .ROM_AW (ROM_AW)
    ) cpu (
        .clk_i      (clk),
        .rst_i      (rst),
        .rom_inst_i (rom_inst_s),
        .rom_ce_o   (rom_ce_s),
        .rom_addr_o (rom_addr_s)
    );

    min_sopc_inst_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_AW    (ROM_AW)
    ) inst_rom0 (
        .ce_i   (rom_ce_s),
        .addr_i (rom_addr_s),
        .inst_o (rom_inst_s)
    );

endmodule

// File: tb/tb_min_sopc.sv
// Bench for min_sopc: programs go into the ROM, an architectural model
// predicts every register write (register, value, edge index), and a
// monitor on the writeback port pops and compares them.
`timescale 1ns/1ps
module tb_min_sopc;

    logic clk;
    logic rst;

    min_sopc #(.ROM_DEPTH(1024), .ROM_AW(10)) dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #1 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          edge_no;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          since_rel = 0;
    logic [31:0] m_regs [0:31];
    logic        pend_v = 1'b0;
    logic [4:0]  pend_a;
    logic [31:0] pend_d;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    // ---------------- architectural model ----------------
    function automatic void model_exec(input logic [31:0] w, output logic we,
                                       output logic [4:0] dst, output logic [31:0] val);
        logic [31:0] a, b, imm;
        a   = m_regs[w[25:21]];
        b   = m_regs[w[20:16]];
        imm = {16'h0, w[15:0]};
        we  = 1'b0;
        dst = 5'd0;
        val = 32'h0;
        case (w[31:26])
            6'h0D: begin we = 1'b1; dst = w[20:16]; val = a | imm; end
            6'h0C: begin we = 1'b1; dst = w[20:16]; val = a & imm; end
            6'h0E: begin we = 1'b1; dst = w[20:16]; val = a ^ imm; end
            6'h0F: begin we = 1'b1; dst = w[20:16]; val = imm << 16; end
            6'h00: begin
                dst = w[15:11];
                case (w[5:0])
                    6'h25: begin we = 1'b1; val = a | b; end
                    6'h24: begin we = 1'b1; val = a & b; end
                    6'h26: begin we = 1'b1; val = a ^ b; end
                    6'h27: begin we = 1'b1; val = ~(a | b); end
                    default: we = 1'b0;
                endcase
            end
            default: we = 1'b0;
        endcase
    endfunction

    // Run the program through the model, queueing the expected writes
    task automatic build_expect(input logic [31:0] prog[$]);
        logic we; logic [4:0] dst; logic [31:0] val;
        for (int k = 0; k < prog.size(); k++) begin
            model_exec(prog[k], we, dst, val);
            if (we && dst != 5'd0) begin
                exp_q.push_back('{addr: dst, data: val, edge_no: 6 + k});
                m_regs[dst] = val;
            end
        end
    endtask

    task automatic load_rom(input logic [31:0] prog[$]);
        for (int i = 0; i < 1024; i++) begin
            dut.inst_rom0.inst_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d writes outstanding expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Hold reset, load, release, and give the pipeline time to drain
    task automatic run_prog(input string name, input logic [31:0] prog[$]);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        load_rom(prog);
        build_expect(prog);
        rst = 1'b0;
        repeat (prog.size() + 8) @(negedge clk);
        check_drained(name);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] r;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        r   = 32'h0;
        case ($urandom_range(0, 11))
            0, 11: r = enc_i(6'h0D, rs, rt, imm);
            1: r = enc_i(6'h0C, rs, rt, imm);
            2: r = enc_i(6'h0E, rs, rt, imm);
            3: r = enc_i(6'h0F, 5'd0, rt, imm);
            4: r = enc_r(rs, rt, rd, 6'h25);
            5: r = enc_r(rs, rt, rd, 6'h24);
            6: r = enc_r(rs, rt, rd, 6'h26);
            7: r = enc_r(rs, rt, rd, 6'h27);
            8: r = 32'h0;
            9: r = {6'h3F, 26'($urandom)};
            default: r = enc_r(rs, rt, rd, 6'h20);
        endcase
        return r;
    endfunction

    // ---------------- edge counter since last reset edge ----------------
    always @(posedge clk) begin
        if (rst) since_rel <= 0;
        else     since_rel <= since_rel + 1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        wr_t e;
        if (pend_v) begin
            checks++;
            if (dut.cpu.register.storage[pend_a] !== pend_d) begin
                errors++;
                $display("FAIL commit r%0d: got %h expected %h",
                         pend_a, dut.cpu.register.storage[pend_a], pend_d);
            end
            pend_v = 1'b0;
        end
        if (!rst && dut.cpu.register.we_i && dut.cpu.register.waddr_i != 5'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected write: got r%0d=%h at edge %0d expected none",
                         dut.cpu.register.waddr_i, dut.cpu.register.wdata_i, since_rel + 1);
            end else begin
                e = exp_q.pop_front();
                if (e.addr != dut.cpu.register.waddr_i || e.data !== dut.cpu.register.wdata_i
                    || e.edge_no != since_rel + 1) begin
                    errors++;
                    $display("FAIL write: got r%0d=%h at edge %0d expected r%0d=%h at edge %0d",
                             dut.cpu.register.waddr_i, dut.cpu.register.wdata_i, since_rel + 1,
                             e.addr, e.data, e.edge_no);
                end
            end
            pend_v = 1'b1;
            pend_a = dut.cpu.register.waddr_i;
            pend_d = dut.cpu.register.wdata_i;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] chain[$];
        logic [31:0] prog[$];
        wr_t         tmp[$];

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        chain = '{enc_i(6'h0D, 5'd0, 5'd5, 16'h1100), enc_i(6'h0D, 5'd5, 5'd5, 16'h0020),
                  enc_i(6'h0D, 5'd5, 5'd5, 16'h4400), enc_i(6'h0D, 5'd5, 5'd5, 16'h0044)};

        // Forwarding chain with absolute timing: reset 0-20 ns, 2 ns clock
        rst = 1'b1;
        load_rom(chain);
        build_expect(chain);
        #20 rst = 1'b0;
        check_val("reset pc", dut.cpu.pc_q, 32'h0);
        #12 check_val("chain@32", dut.cpu.register.storage[5], 32'h0000_1100);
        #2  check_val("chain@34", dut.cpu.register.storage[5], 32'h0000_1120);
        #2  check_val("chain@36", dut.cpu.register.storage[5], 32'h0000_5520);
        #2  check_val("chain@38", dut.cpu.register.storage[5], 32'h0000_5564);
        repeat (6) @(negedge clk);
        check_drained("chain");

        // Give every register a known value so later models start in sync
        prog = {};
        for (int r = 1; r < 32; r++) prog.push_back(enc_r(5'd0, 5'd0, 5'(r), 6'h25));
        run_prog("clear", prog);

        prog = '{enc_i(6'h0D, 5'd0, 5'd1, 16'h00F0), 32'h0, enc_r(5'd1, 5'd0, 5'd2, 6'h25)};
        run_prog("mem_fwd", prog);
        check_val("mem_fwd r2", dut.cpu.register.storage[2], 32'h0000_00F0);

        prog = '{enc_i(6'h0D, 5'd0, 5'd3, 16'h0F0F), 32'h0, 32'h0, enc_i(6'h0E, 5'd3, 5'd4, 16'h00FF)};
        run_prog("wthru", prog);
        check_val("wthru r4", dut.cpu.register.storage[4], 32'h0000_0FF0);

        prog = '{enc_i(6'h0D, 5'd0, 5'd6, 16'h7777), enc_i(6'h0D, 5'd0, 5'd0, 16'h1234),
                 enc_r(5'd0, 5'd0, 5'd6, 6'h25)};
        run_prog("zero", prog);
        check_val("zero r0", dut.cpu.register.storage[0], 32'h0);
        check_val("zero r6", dut.cpu.register.storage[6], 32'h0);

        prog = '{enc_i(6'h0F, 5'd0, 5'd7, 16'hABCD), enc_r(5'd7, 5'd0, 5'd8, 6'h27), 32'hFC00_0000};
        run_prog("lui_nor", prog);
        check_val("lui r7", dut.cpu.register.storage[7], 32'hABCD_0000);
        check_val("nor r8", dut.cpu.register.storage[8], 32'h5432_FFFF);

        // Mid-run reset: two chain writes land, the third is in WB when reset hits
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        load_rom(chain);
        build_expect(chain);
        tmp = exp_q;
        exp_q.delete();
        exp_q.push_back(tmp[0]);
        exp_q.push_back(tmp[1]);
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst pc", dut.cpu.pc_q, 32'h0);
        check_val("midrst ce", 32'(dut.cpu.ce_q), 32'h0);
        check_val("midrst discard", dut.cpu.register.storage[5], 32'h0000_1120);
        repeat (12) @(negedge clk);
        check_drained("midrst");
        check_val("midrst r5", dut.cpu.register.storage[5], 32'h0000_5564);

        // Random dependent programs over a small register window
        for (int p = 0; p < 4; p++) begin
            prog = {};
            for (int k = 0; k < 24; k++) prog.push_back(rand_inst());
            run_prog($sformatf("rand%0d", p), prog);
        end

        for (int r = 0; r < 32; r++) begin
            check_val($sformatf("final r%0d", r), dut.cpu.register.storage[r], m_regs[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
